io_sw_conditioner: RTL and testbench

//  Conditions raw board switches before they reach the core's i_io_sw input (LSU switch read path).
//  Per-bit: N-stage synchronizer, then a debounce counter/FSM.
//  o_io_sw changes only after the synchronized level has been stable for DEBOUNCE_CYCLES clocks.

---
 rtl/io_sw_conditioner_if.sv | 22 ++
 rtl/io_sw_conditioner.sv | 117 +++++++++++
 tb/tb_io_sw_conditioner.sv | 171 +++++++++++++++++
 3 files changed

// File: rtl/io_sw_conditioner_if.sv
// Switch-conditioner signal bundle: raw pins in, debounced level (and optional rise flags) out.
// The edge-capture signals exist only when SW_EDGE_CAPTURE_EN is defined.
interface io_sw_conditioner_if #(
  parameter int NUM_SW = 32
);
  // No valid/ready here: every signal is a level, sampled on every clock edge.
  logic [NUM_SW-1:0] i_sw_raw;
  logic [NUM_SW-1:0] o_io_sw;
  logic [NUM_SW-1:0] dbg_counting;
`ifdef SW_EDGE_CAPTURE_EN
  logic [NUM_SW-1:0] i_edge_clr;
  logic [NUM_SW-1:0] o_sw_rise;

  modport master (output i_sw_raw, output i_edge_clr,
                  input o_io_sw, input o_sw_rise, input dbg_counting);
  modport slave  (input i_sw_raw, input i_edge_clr,
                  output o_io_sw, output o_sw_rise, output dbg_counting);
`else
  modport master (output i_sw_raw, input o_io_sw, input dbg_counting);
  modport slave  (input i_sw_raw, output o_io_sw, output dbg_counting);
`endif
endinterface

// File: rtl/io_sw_conditioner.sv
// Per-bit synchronizer + debounce FSM for board switches feeding the core's i_io_sw.
// Define SW_EDGE_CAPTURE_EN to add sticky rising-edge flags (o_sw_rise / i_edge_clr).
module io_sw_conditioner #(
  parameter int                NUM_SW          = 32,
  parameter int                SYNC_STAGES     = 2,
  parameter int                DEBOUNCE_CYCLES = 500000,
  parameter logic [NUM_SW-1:0] RESET_VAL       = '0
) (
  input logic                  i_clk,
  input logic                  i_reset,
  io_sw_conditioner_if.slave   bus
);
  localparam int CNT_W = (DEBOUNCE_CYCLES < 1) ? 1 : $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES);
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  typedef enum logic {IDLE = 1'b0, COUNT = 1'b1} state_t;

  generate
    if (SYNC_STAGES < 2) begin : g_bad_sync
      $error("io_sw_conditioner: SYNC_STAGES must be >= 2");
    end
    if (DEBOUNCE_CYCLES < 1) begin : g_bad_deb
      $error("io_sw_conditioner: DEBOUNCE_CYCLES must be >= 1");
    end
    if (NUM_SW < 1 || NUM_SW > 32) begin : g_bad_num
      $error("io_sw_conditioner: NUM_SW must be 1..32");
    end
  endgenerate

  logic [NUM_SW-1:0] sync_q [SYNC_STAGES];
  logic [NUM_SW-1:0] s;

  // Plain shift chain: nothing may sit between stages or metastability leaks through.
  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      for (int k = 0; k < SYNC_STAGES; k++) sync_q[k] <= '0;
    end else begin
      sync_q[0] <= bus.i_sw_raw;
      for (int k = 1; k < SYNC_STAGES; k++) sync_q[k] <= sync_q[k-1];
    end
  end

  assign s = sync_q[SYNC_STAGES-1];

  state_t            state_q [NUM_SW];
  state_t            state_d [NUM_SW];
  logic [CNT_W-1:0]  cnt_q   [NUM_SW];
  logic [CNT_W-1:0]  cnt_d   [NUM_SW];
  logic [NUM_SW-1:0] io_sw_q;
  logic [NUM_SW-1:0] io_sw_d;
  logic [NUM_SW-1:0] counting;

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    io_sw_d  = io_sw_q;
    counting = '0;
    for (int i = 0; i < NUM_SW; i++) begin
      counting[i] = (state_q[i] == COUNT);
      case (state_q[i])
        IDLE: begin
          cnt_d[i] = '0;
          if (s[i] != io_sw_q[i]) begin
            state_d[i] = COUNT;
            cnt_d[i]   = CNT_ONE;
          end
        end
        COUNT: begin
          if (s[i] == io_sw_q[i]) begin
            state_d[i] = IDLE;
            cnt_d[i]   = '0;
          end else if (cnt_q[i] == CNT_MAX) begin
            // Level held for the full window: commit it and start over.
            io_sw_d[i] = s[i];
            state_d[i] = IDLE;
            cnt_d[i]   = '0;
          end else begin
            cnt_d[i] = cnt_q[i] + CNT_ONE;
          end
        end
      endcase
    end
  end

  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      for (int i = 0; i < NUM_SW; i++) begin
        state_q[i] <= IDLE;
        cnt_q[i]   <= '0;
      end
      io_sw_q <= RESET_VAL;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      io_sw_q <= io_sw_d;
    end
  end

  assign bus.o_io_sw      = io_sw_q;
  assign bus.dbg_counting = counting;

`ifdef SW_EDGE_CAPTURE_EN
  logic [NUM_SW-1:0] rise_q;

  // A new 0->1 commit beats a simultaneous clear so no press is lost.
  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      rise_q <= '0;
    end else begin
      rise_q <= (rise_q & ~bus.i_edge_clr) | (io_sw_d & ~io_sw_q);
    end
  end

  assign bus.o_sw_rise = rise_q;
`endif
endmodule

// File: tb/tb_io_sw_conditioner.sv
// Bench for io_sw_conditioner with NUM_SW=4, SYNC_STAGES=2, DEBOUNCE_CYCLES=4, RESET_VAL=0.
// Raw changes land 7 edges later; edge-flag checks compile in with SW_EDGE_CAPTURE_EN.
module tb_io_sw_conditioner;
  localparam int NUM_SW = 4;
  localparam int LAT    = 7;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  io_sw_conditioner_if #(.NUM_SW(NUM_SW)) bus ();

  io_sw_conditioner #(
    .NUM_SW(NUM_SW), .SYNC_STAGES(2), .DEBOUNCE_CYCLES(4), .RESET_VAL(4'b0000)
  ) dut (
    .i_clk   (clk),
    .i_reset (rst_n),
    .bus     (bus.slave)
  );

  int n_checks = 0;
  int n_errors = 0;
  logic [NUM_SW-1:0] exp_q[$];

  typedef struct {
    logic [NUM_SW-1:0] raw;
    int                hold;
    logic [NUM_SW-1:0] exp;
  } vec_t;
  vec_t vecs[6];

  task automatic check(input string name, input logic [NUM_SW-1:0] act,
                       input logic [NUM_SW-1:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic sb_check(input string name, input logic [NUM_SW-1:0] act);
    if (exp_q.size() == 0) begin
      n_checks++;
      n_errors++;
      $display("FAIL %s: got %h expected <empty scoreboard>", name, act);
    end else begin
      check(name, act, exp_q.pop_front());
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Drive a raw value and expect the old output for 6 edges, the new one on edge 7.
  task automatic step_expect(input string name, input logic [NUM_SW-1:0] raw,
                             input logic [NUM_SW-1:0] oldv, input logic [NUM_SW-1:0] newv);
    bus.i_sw_raw = raw;
    for (int e = 1; e <= LAT; e++) begin
      exp_q.push_back((e < LAT) ? oldv : newv);
      tick();
      sb_check($sformatf("%s edge%0d", name, e), bus.o_io_sw);
    end
  endtask

  initial begin
    vecs[0] = '{raw: 4'h0, hold: 8, exp: 4'h0};
    vecs[1] = '{raw: 4'h5, hold: 8, exp: 4'h5};
    vecs[2] = '{raw: 4'h5, hold: 3, exp: 4'h5};
    vecs[3] = '{raw: 4'hA, hold: 6, exp: 4'h5};
    vecs[4] = '{raw: 4'hA, hold: 1, exp: 4'hA};
    vecs[5] = '{raw: 4'h0, hold: 8, exp: 4'h0};

    bus.i_sw_raw = 4'hF;
`ifdef SW_EDGE_CAPTURE_EN
    bus.i_edge_clr = '0;
`endif

    // Reset held with all switches high: outputs must stay at RESET_VAL.
    for (int c = 0; c < 5; c++) begin
      tick();
      check($sformatf("reset_hold%0d", c), bus.o_io_sw, 4'h0);
`ifdef SW_EDGE_CAPTURE_EN
      check($sformatf("reset_rise%0d", c), bus.o_sw_rise, 4'h0);
`endif
    end
    rst_n = 1'b1;
    step_expect("reset_release", 4'hF, 4'h0, 4'hF);

    for (int v = 0; v < 6; v++) begin
      bus.i_sw_raw = vecs[v].raw;
      exp_q.push_back(vecs[v].exp);
      repeat (vecs[v].hold) tick();
      sb_check($sformatf("vec%0d", v), bus.o_io_sw);
    end

    step_expect("clean_step", 4'h1, 4'h0, 4'h1);

    // Bit1 bounces in 2-cycle runs; output must hold until the final level settles.
    for (int b = 0; b < 4; b++) begin
      bus.i_sw_raw = (b % 2 == 0) ? 4'h3 : 4'h1;
      repeat (2) begin
        tick();
        check($sformatf("bounce%0d", b), bus.o_io_sw, 4'h1);
      end
    end
    step_expect("bounce_settle", 4'h3, 4'h1, 4'h3);

    bus.i_sw_raw = 4'h7;
    repeat (3) tick();
    bus.i_sw_raw = 4'h3;
    for (int c = 0; c < 10; c++) begin
      tick();
      check($sformatf("glitch%0d", c), bus.o_io_sw, 4'h3);
    end

    // Reset lands mid-count on bit3 and must clear outputs without a clock edge.
    bus.i_sw_raw = 4'hB;
    repeat (4) tick();
    check("counting_bit3", bus.dbg_counting, 4'h8);
    rst_n = 1'b0;
    #1;
    check("async_reset_out", bus.o_io_sw, 4'h0);
    check("async_reset_fsm", bus.dbg_counting, 4'h0);
    tick();
    tick();
    rst_n = 1'b1;
    step_expect("reset_recover", 4'hB, 4'h0, 4'hB);

`ifdef SW_EDGE_CAPTURE_EN
    check("rise_after_recover", bus.o_sw_rise, 4'hB);
    bus.i_edge_clr = 4'hF;
    tick();
    bus.i_edge_clr = 4'h0;
    check("rise_clear_all", bus.o_sw_rise, 4'h0);
    step_expect("fall_bit0", 4'hA, 4'hB, 4'hA);
    check("rise_after_fall", bus.o_sw_rise, 4'h0);

    bus.i_sw_raw = 4'hB;
    for (int e = 1; e <= LAT; e++) begin
      tick();
      check($sformatf("rise_bit0 edge%0d", e), bus.o_sw_rise, (e == LAT) ? 4'h1 : 4'h0);
      check($sformatf("rise_out edge%0d", e), bus.o_io_sw, (e == LAT) ? 4'hB : 4'hA);
    end
    bus.i_edge_clr = 4'h1;
    tick();
    bus.i_edge_clr = 4'h0;
    check("rise_clear_bit0", bus.o_sw_rise, 4'h0);

    step_expect("fall_again", 4'hA, 4'hB, 4'hA);
    bus.i_sw_raw = 4'hB;
    repeat (LAT - 1) tick();
    bus.i_edge_clr = 4'hF;
    tick();
    bus.i_edge_clr = 4'h0;
    check("set_beats_clear", bus.o_sw_rise, 4'h1);
    check("set_beats_clear_out", bus.o_io_sw, 4'hB);
    tick();
    check("rise_sticky", bus.o_sw_rise, 4'h1);
`endif

    if (exp_q.size() != 0) begin
      n_checks++;
      n_errors++;
      $display("FAIL scoreboard_drain: got %0d left expected 0", exp_q.size());
    end
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end
endmodule
